cam_cmd_initiator: RTL and testbench
====================================

Name: cam_cmd_initiator

Overview:
- Requester-side controller for the content-addressable memory (CAM) block. It turns a valid/ready command stream into correctly sequenced CAM write and search cycles.
- Write sequencing honours the CAM's busy (erase/write) indication. Search results (match flag, match address) are sampled at a fixed latency.
- Each command produces exactly one response on a valid/ready response channel.
- Sits between the pass-keeper command logic and the CAM top level. It is the only driver of the CAM's write_enable, din, cmp_din and write_addr inputs.

Parameters:
- DATA_WIDTH, 4, key width; must match the CAM's DATA_WIDTH.
- ADDR_WIDTH, 2, CAM address width in log2(words); must match the CAM's ADDR_WIDTH.
- SEARCH_LAT, 1, clock cycles from driving the search key to sampling the CAM's match and match address (range 1..15).
- BUSY_TIMEOUT, 16, maximum cycles spent in any single write phase before the write is aborted with an error (range 2..255).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both 1.
- cmd_write  in  1  1 = write cmd_key to cmd_addr; 0 = search for cmd_key.
- cmd_key  in  DATA_WIDTH  key to write or to search for.
- cmd_addr  in  ADDR_WIDTH  write address; ignored for searches.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both 1.
- rsp_write  out  1  echo of cmd_write for this response.
- rsp_match  out  1  search hit (always 0 for writes).
- rsp_addr  out  ADDR_WIDTH  matched address (search) or echoed cmd_addr (write).
- rsp_err  out  1  write timed out.
- cam_write_enable  out  1  to CAM write_enable.
- cam_din  out  DATA_WIDTH  to CAM din.
- cam_cmp_din  out  DATA_WIDTH  to CAM cmp_din.
- cam_write_addr  out  ADDR_WIDTH  to CAM write_addr.
- cam_busy  in  1  from CAM busy.
- cam_match  in  1  from CAM match.
- cam_match_addr  in  ADDR_WIDTH  from CAM match_addr.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - All outputs 0, including cmd_ready, rsp_valid and cam_write_enable.
  - Internal counters and captured command fields cleared.
  - Reset mid-operation abandons the command with no response. cam_write_enable drops immediately.
- cmd_ready = 1 only in IDLE. Only one command is outstanding at a time.
- On acceptance:
  - cmd_write, cmd_key and cmd_addr are registered.
  - cam_din, cam_cmp_din and cam_write_addr are driven from the registered values. They stay stable until the next acceptance.
- States:
  - IDLE: on command accept, go to WR_REQ if cmd_write=1, else SRCH.
  - WR_REQ:
    - cam_write_enable=1.
    - Wait for cam_busy=1, then go to WR_BUSY (wait counter reset to 0).
    - If the wait counter reaches BUSY_TIMEOUT first, set err and go to RESP.
  - WR_BUSY:
    - cam_write_enable stays 1.
    - When cam_busy=0, go to RESP with err=0.
    - If the wait counter reaches BUSY_TIMEOUT first, set err and go to RESP.
  - SRCH:
    - cam_write_enable=0.
    - Counter runs 1..SEARCH_LAT. In the cycle the count equals SEARCH_LAT, capture cam_match and cam_match_addr, then go to RESP.
  - RESP:
    - cam_write_enable=0; rsp_valid=1.
    - Response fields are held stable while rsp_ready=0.
    - On handshake, go to IDLE. cmd_ready rises the following cycle; no command is accepted in the handshake cycle.
- cam_write_enable:
  - Registered output; first high in the cycle after command acceptance.
  - Falls in the cycle after cam_busy=0 is seen in WR_BUSY, or after a timeout.
  - Never high outside WR_REQ and WR_BUSY.
- Write responses:
  - rsp_match = 0; rsp_addr = the captured command address.
  - rsp_err = 1 only on timeout. After a timeout, CAM contents are unspecified.
- Search responses:
  - rsp_err = 0.
  - rsp_match and rsp_addr are the sampled CAM values. rsp_addr = 0 when there is no match.
  - Multiple hits resolve to the lowest matching address (the CAM's priority rule); this block passes the value through unchanged.
- cam_busy=1 observed in IDLE or SRCH is ignored.
- Wait counter:
  - Width ceil(log2(BUSY_TIMEOUT+1)); saturates, no wrap.
  - Cleared on every state entry.
- Latency, write command with CAM busy for B cycles: rsp_valid rises B+2 cycles after acceptance, for B < BUSY_TIMEOUT.
- Latency, search command: rsp_valid rises SEARCH_LAT+1 cycles after acceptance.

Test Plan:
- Reset release, then idle 5 cycles → cmd_ready=1, rsp_valid=0, cam_write_enable=0 throughout.
- Write key 0xA to addr 2; CAM model holds busy for 3 cycles → cam_write_enable high until busy falls; response rsp_write=1, rsp_addr=2, rsp_err=0, rsp_match=0.
- After the previous write, search 0xA; then search 0x5 (absent) → first response rsp_match=1, rsp_addr=2; second response rsp_match=0, rsp_addr=0; each arrives SEARCH_LAT+1 cycles after acceptance.
- Write with cam_busy stuck at 0 (BUSY_TIMEOUT=16) → rsp_err=1 after 16 cycles in WR_REQ; cam_write_enable drops; the next command is accepted normally.
- Hold rsp_ready=0 for 7 cycles while cmd_valid=1 with a new command → rsp fields stable, cmd_ready=0; the new command is accepted 1 cycle after the response handshake.
- Assert rst=0 in the middle of WR_BUSY → cam_write_enable=0 and rsp_valid=0 immediately (asynchronously); after release, state is IDLE with cmd_ready=1.

Source files
------------

// File: rtl/cam_cmd_if.sv
// Command/response handshake bundle between the pass-keeper and the CAM initiator.
interface cam_cmd_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 2
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [DATA_WIDTH-1:0] cmd_key;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_write;
    logic                  rsp_match;
    logic [ADDR_WIDTH-1:0] rsp_addr;
    logic                  rsp_err;

    modport master (
        output cmd_valid, cmd_write, cmd_key, cmd_addr, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_write, rsp_match, rsp_addr,
        input  rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_key, cmd_addr, rsp_ready,
        output cmd_ready, rsp_valid, rsp_write, rsp_match, rsp_addr,
        output rsp_err
    );
endinterface

// File: rtl/cam_cmd_initiator.sv
// Requester-side CAM controller: sequences write and search cycles
// for a single outstanding command and returns one response each.
module cam_cmd_initiator #(
    parameter int DATA_WIDTH   = 4,
    parameter int ADDR_WIDTH   = 2,
    parameter int SEARCH_LAT   = 1,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cam_cmd_if.slave              cmd_bus,
    output logic                  cam_write_enable,
    output logic [DATA_WIDTH-1:0] cam_din,
    output logic [DATA_WIDTH-1:0] cam_cmp_din,
    output logic [ADDR_WIDTH-1:0] cam_write_addr,
    input  logic                  cam_busy,
    input  logic                  cam_match,
    input  logic [ADDR_WIDTH-1:0] cam_match_addr
);
    // Counter also serves search latency, so keep at least 4 bits.
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam int CW = (TW > 4) ? TW : 4;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] LAT_END = CW'(SEARCH_LAT);
    localparam logic [CW-1:0] TMO_END = CW'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_BUSY,
        SRCH,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ready_q, we_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] key_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  match_q, err_q;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic                  accept, load_wr, load_sr, timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        load_wr = 1'b0;
        load_sr = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_bus.cmd_valid && ready_q) begin
                    accept  = 1'b1;
                    state_d = cmd_bus.cmd_write ? WR_REQ : SRCH;
                end
            end
            WR_REQ: begin
                if (cam_busy) begin
                    state_d = WR_BUSY;
                end else if (cnt_q == TMO_END) begin
                    timeout = 1'b1;
                    load_wr = 1'b1;
                    state_d = RESP;
                end
            end
            WR_BUSY: begin
                if (!cam_busy || cnt_q == TMO_END) begin
                    timeout = cam_busy;
                    load_wr = 1'b1;
                    state_d = RESP;
                end
            end
            SRCH: begin
                if (cnt_q == LAT_END) begin
                    load_sr = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (cmd_bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;
        else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
        else cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            wr_q    <= 1'b0;
            key_q   <= '0;
            addr_q  <= '0;
            match_q <= 1'b0;
            raddr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= (state_d == IDLE);
            we_q    <= (state_d == WR_REQ) || (state_d == WR_BUSY);
            if (accept) begin
                wr_q   <= cmd_bus.cmd_write;
                key_q  <= cmd_bus.cmd_key;
                addr_q <= cmd_bus.cmd_addr;
            end
            if (load_wr) begin
                match_q <= 1'b0;
                raddr_q <= addr_q;
                err_q   <= timeout;
            end
            if (load_sr) begin
                match_q <= cam_match;
                raddr_q <= cam_match ? cam_match_addr : '0;
                err_q   <= 1'b0;
            end
        end
    end

    assign cmd_bus.cmd_ready = ready_q;
    assign cmd_bus.rsp_valid = (state_q == RESP);
    assign cmd_bus.rsp_write = wr_q;
    assign cmd_bus.rsp_match = match_q;
    assign cmd_bus.rsp_addr  = raddr_q;
    assign cmd_bus.rsp_err   = err_q;

    assign cam_write_enable = we_q;
    assign cam_din          = key_q;
    assign cam_cmp_din      = key_q;
    assign cam_write_addr   = addr_q;
endmodule

// File: tb/tb_cam_cmd_initiator.sv
// Directed bench for cam_cmd_initiator with a small behavioural CAM
// (registered busy pulse, one-cycle search, lowest-address priority).
module tb_cam_cmd_initiator;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cam_write_enable;
    logic [3:0] cam_din;
    logic [3:0] cam_cmp_din;
    logic [1:0] cam_write_addr;
    logic       cam_busy = 1'b0;
    logic       cam_match = 1'b0;
    logic [1:0] cam_match_addr = 2'd0;

    int compared = 0;
    int mismatched = 0;

    logic [3:0] mem [4];
    logic [3:0] vld = 4'b0;
    int         busy_len = 3;
    bit         stuck = 1'b0;
    bit         started = 1'b0;
    int         left = 0;

    cam_cmd_if #(.DATA_WIDTH(4), .ADDR_WIDTH(2)) bus ();

    cam_cmd_initiator #(
        .DATA_WIDTH(4),
        .ADDR_WIDTH(2),
        .SEARCH_LAT(1),
        .BUSY_TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_bus(bus.slave),
        .cam_write_enable(cam_write_enable),
        .cam_din(cam_din),
        .cam_cmp_din(cam_cmp_din),
        .cam_write_addr(cam_write_addr),
        .cam_busy(cam_busy),
        .cam_match(cam_match),
        .cam_match_addr(cam_match_addr)
    );

    always #5 clk = ~clk;

    // CAM model: busy rises the edge after write_enable, lasts busy_len.
    always @(posedge clk) begin
        if (cam_write_enable && !started && !stuck) begin
            started  <= 1'b1;
            cam_busy <= 1'b1;
            left     <= busy_len;
            mem[cam_write_addr] <= cam_din;
            vld[cam_write_addr] <= 1'b1;
        end else if (cam_busy) begin
            if (left <= 1) cam_busy <= 1'b0;
            left <= left - 1;
        end
        if (!cam_write_enable) started <= 1'b0;
        cam_match      <= 1'b0;
        cam_match_addr <= 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (vld[i] && mem[i] == cam_cmp_din) begin
                cam_match      <= 1'b1;
                cam_match_addr <= 2'(i);
            end
        end
    end

    task automatic accept_cmd(input bit w, input logic [3:0] k,
                              input logic [1:0] a);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_key   = k;
        bus.cmd_addr  = a;
        while (!bus.cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.cmd_ready) begin
            compared++;
            mismatched++;
            $display("FAIL accept: cmd_ready=0 after 50 cycles, need 1");
        end else begin
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output int wec);
        lat = 0;
        wec = 0;
        while (!bus.rsp_valid && lat < 100) begin
            if (cam_write_enable) wec++;
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.rsp_valid) begin
            compared++;
            mismatched++;
            $display("FAIL rsp_wait: rsp_valid=0 after 100 cycles, need 1");
        end
    endtask

    task automatic handshake();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({bus.cmd_ready, bus.rsp_valid, cam_write_enable} !== 3'b000) begin
            mismatched++;
            $display("FAIL in_reset: got rdy/vld/we=%b, need 000",
                     {bus.cmd_ready, bus.rsp_valid, cam_write_enable});
        end
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            compared++;
            if ({bus.cmd_ready, bus.rsp_valid, cam_write_enable} !== 3'b100)
            begin
                mismatched++;
                $display("FAIL idle: got rdy/vld/we=%b, need 100",
                         {bus.cmd_ready, bus.rsp_valid, cam_write_enable});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_write();
        int lat, wec;
        busy_len = 3;
        stuck = 1'b0;
        accept_cmd(1'b1, 4'hA, 2'd2);
        wait_rsp(lat, wec);
        compared++;
        if (lat != 5) begin
            mismatched++;
            $display("FAIL wr_lat: got %0d, need 5", lat);
        end
        compared++;
        if (wec != 5) begin
            mismatched++;
            $display("FAIL wr_we_cycles: got %0d, need 5", wec);
        end
        compared++;
        if ({bus.rsp_write, bus.rsp_match, bus.rsp_addr, bus.rsp_err}
            !== 5'b1_0_10_0) begin
            mismatched++;
            $display("FAIL wr_rsp: got %b, need 10100",
                {bus.rsp_write, bus.rsp_match, bus.rsp_addr, bus.rsp_err});
        end
        compared++;
        if (cam_write_enable !== 1'b0) begin
            mismatched++;
            $display("FAIL wr_we_resp: got %b, need 0", cam_write_enable);
        end
        handshake();
        compared++;
        if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
            mismatched++;
            $display("FAIL wr_after_hs: got vld/rdy=%b, need 01",
                     {bus.rsp_valid, bus.cmd_ready});
        end
    endtask

    task automatic test_search();
        int lat, wec;
        accept_cmd(1'b0, 4'hA, 2'd0);
        wait_rsp(lat, wec);
        compared++;
        if (lat != 2) begin
            mismatched++;
            $display("FAIL srch_hit_lat: got %0d, need 2", lat);
        end
        compared++;
        if ({bus.rsp_write, bus.rsp_match, bus.rsp_addr, bus.rsp_err}
            !== 5'b0_1_10_0) begin
            mismatched++;
            $display("FAIL srch_hit: got %b, need 01100",
                {bus.rsp_write, bus.rsp_match, bus.rsp_addr, bus.rsp_err});
        end
        handshake();
        accept_cmd(1'b0, 4'h5, 2'd1);
        wait_rsp(lat, wec);
        compared++;
        if (lat != 2) begin
            mismatched++;
            $display("FAIL srch_miss_lat: got %0d, need 2", lat);
        end
        compared++;
        if ({bus.rsp_write, bus.rsp_match, bus.rsp_addr, bus.rsp_err}
            !== 5'b0_0_00_0) begin
            mismatched++;
            $display("FAIL srch_miss: got %b, need 00000",
                {bus.rsp_write, bus.rsp_match, bus.rsp_addr, bus.rsp_err});
        end
        handshake();
    endtask

    task automatic test_timeout();
        int lat, wec;
        stuck = 1'b1;
        accept_cmd(1'b1, 4'h7, 2'd1);
        wait_rsp(lat, wec);
        compared++;
        if (lat != 16 || wec != 16) begin
            mismatched++;
            $display("FAIL tmo_lat: got lat %0d we %0d, need 16 16", lat, wec);
        end
        compared++;
        if ({bus.rsp_write, bus.rsp_match, bus.rsp_addr, bus.rsp_err,
             cam_write_enable} !== 6'b1_0_01_1_0) begin
            mismatched++;
            $display("FAIL tmo_rsp: got %b, need 100110",
                {bus.rsp_write, bus.rsp_match, bus.rsp_addr, bus.rsp_err,
                 cam_write_enable});
        end
        handshake();
        stuck = 1'b0;
        busy_len = 2;
        accept_cmd(1'b1, 4'h3, 2'd0);
        wait_rsp(lat, wec);
        compared++;
        if (lat != 4) begin
            mismatched++;
            $display("FAIL post_tmo_lat: got %0d, need 4", lat);
        end
        compared++;
        if ({bus.rsp_write, bus.rsp_match, bus.rsp_addr, bus.rsp_err}
            !== 5'b1_0_00_0) begin
            mismatched++;
            $display("FAIL post_tmo_rsp: got %b, need 10000",
                {bus.rsp_write, bus.rsp_match, bus.rsp_addr, bus.rsp_err});
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int lat, wec;
        accept_cmd(1'b0, 4'hA, 2'd0);
        wait_rsp(lat, wec);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_key   = 4'h3;
        bus.cmd_addr  = 2'd0;
        for (int i = 0; i < 7; i++) begin
            compared++;
            if ({bus.rsp_valid, bus.cmd_ready, bus.rsp_write, bus.rsp_match,
                 bus.rsp_addr, bus.rsp_err} !== 7'b1_0_0_1_10_0) begin
                mismatched++;
                $display("FAIL hold_%0d: got %b, need 1001100", i,
                    {bus.rsp_valid, bus.cmd_ready, bus.rsp_write,
                     bus.rsp_match, bus.rsp_addr, bus.rsp_err});
            end
            @(posedge clk); #1;
        end
        handshake();
        compared++;
        if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
            mismatched++;
            $display("FAIL hs_ready: got vld/rdy=%b, need 01",
                     {bus.rsp_valid, bus.cmd_ready});
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        compared++;
        if (bus.cmd_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_accept: got cmd_ready %b, need 0",
                     bus.cmd_ready);
        end
        wait_rsp(lat, wec);
        compared++;
        if (lat != 2 || {bus.rsp_match, bus.rsp_addr} !== 3'b1_00) begin
            mismatched++;
            $display("FAIL b2b_rsp: got lat %0d m/a %b, need 2 100", lat,
                     {bus.rsp_match, bus.rsp_addr});
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        int lat, wec;
        busy_len = 10;
        accept_cmd(1'b1, 4'h9, 2'd3);
        repeat (4) @(posedge clk);
        #1;
        compared++;
        if ({cam_write_enable, cam_busy} !== 2'b11) begin
            mismatched++;
            $display("FAIL mid_busy: got we/busy %b, need 11",
                     {cam_write_enable, cam_busy});
        end
        #2 rst = 1'b0;
        #1;
        compared++;
        if ({cam_write_enable, bus.rsp_valid, bus.cmd_ready} !== 3'b000) begin
            mismatched++;
            $display("FAIL async_rst: got we/vld/rdy %b, need 000",
                     {cam_write_enable, bus.rsp_valid, bus.cmd_ready});
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        compared++;
        if ({cam_write_enable, bus.rsp_valid, bus.cmd_ready} !== 3'b001) begin
            mismatched++;
            $display("FAIL post_rst: got we/vld/rdy %b, need 001",
                     {cam_write_enable, bus.rsp_valid, bus.cmd_ready});
        end
        accept_cmd(1'b0, 4'h9, 2'd0);
        wait_rsp(lat, wec);
        compared++;
        if (lat != 2 || {bus.rsp_match, bus.rsp_addr, bus.rsp_err}
            !== 4'b1_11_0) begin
            mismatched++;
            $display("FAIL post_rst_srch: got lat %0d %b, need 2 1110", lat,
                     {bus.rsp_match, bus.rsp_addr, bus.rsp_err});
        end
        handshake();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_key   = 4'h0;
        bus.cmd_addr  = 2'd0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_write();
        test_search();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
